// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC, ROM address, IF/ID register
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        fetch_en,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_fault,
    output logic [31:0] fetch_count
);

    // First byte address past the ROM; 33 bits so a full 4 GiB ROM cannot overflow.
    localparam logic [32:0] IMEM_LIMIT = {1'b0, 32'(IMEM_WORDS)} << 2;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic        load;
    logic        transfer;

    assign imem_a   = pc;
    assign pc_plus4 = pc + 32'd4;
    assign fault    = ({1'b0, pc} >= IMEM_LIMIT);
    assign transfer = id_valid & id_ready;
    assign load     = fetch_en & (~id_valid | id_ready) & ~redirect_valid;

    // PC and IF/ID register: redirect beats load, load beats drain, else hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_fault    <= 1'b0;
            id_inst     <= NOP_INST;
            id_pc       <= 32'd0;
            id_pc4      <= 32'd0;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            pc       <= {redirect_target[31:2], 2'b00};
            id_valid <= 1'b0;
            id_fault <= 1'b0;
        end else if (load) begin
            id_inst     <= fault ? NOP_INST : imem_inst;
            id_pc       <= pc;
            id_pc4      <= pc_plus4;
            id_fault    <= fault;
            id_valid    <= 1'b1;
            pc          <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
        end else if (transfer) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - table-driven self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clock;
    logic        resetn;
    logic        fetch_en;
    logic [31:0] imem_a;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_fault;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(64),
        .NOP_INST  (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .fetch_en       (fetch_en),
        .imem_a         (imem_a),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .id_fault       (id_fault),
        .fetch_count    (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM contents: three fixed words, the rest a recognisable address pattern.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h3C03_C000;
            32'h0000_0004: rom_word = 32'h2005_0021;
            32'h0000_001C: rom_word = 32'hAC65_0000;
            default:       rom_word = 32'h1000_0000 ^ a;
        endcase
    endfunction

    assign imem_inst = rom_word(imem_a);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_fault;
        logic [31:0] e_imem_a;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[21];

    task automatic apply(input int i);
        fetch_en        = vecs[i].fe;
        id_ready        = vecs[i].rdy;
        redirect_valid  = vecs[i].rv;
        redirect_target = vecs[i].tgt;
        @(posedge clock);
        #1;
        chk($sformatf("v%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
        chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].e_pc);
        chk($sformatf("v%0d id_pc4", i), id_pc4, vecs[i].e_pc + 32'd4);
        chk($sformatf("v%0d id_inst", i), id_inst, vecs[i].e_inst);
        chk($sformatf("v%0d id_fault", i), {31'd0, id_fault}, {31'd0, vecs[i].e_fault});
        chk($sformatf("v%0d imem_a", i), imem_a, vecs[i].e_imem_a);
        chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_fc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          fe    rdy   rv    tgt            valid pc             inst           flt   imem_a         fc
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 32'h3C03_C000, 1'b0, 32'h0000_0004, 32'd1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 32'h2005_0021, 1'b0, 32'h0000_0008, 32'd2};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h1000_0008, 1'b0, 32'h0000_000C, 32'd3};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h1000_0008, 1'b0, 32'h0000_000C, 32'd3};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h1000_0008, 1'b0, 32'h0000_000C, 32'd3};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h1000_0008, 1'b0, 32'h0000_000C, 32'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 32'h1000_000C, 1'b0, 32'h0000_0010, 32'd4};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 32'h1000_000C, 1'b0, 32'h0000_0010, 32'd4};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_001E, 1'b0, 32'h0000_000C, 32'h1000_000C, 1'b0, 32'h0000_001C, 32'd4};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_001C, 32'hAC65_0000, 1'b0, 32'h0000_0020, 32'd5};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_001C, 32'hAC65_0000, 1'b0, 32'h0000_0100, 32'd5};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0104, 32'd6};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 32'h0000_0000, 1'b1, 32'h0000_0108, 32'd7};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h0000_0023, 1'b0, 32'h0000_0104, 32'h0000_0000, 1'b0, 32'h0000_0020, 32'd7};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0020, 32'h1000_0020, 1'b0, 32'h0000_0024, 32'd8};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 32'h1000_0020, 1'b0, 32'h0000_0024, 32'd8};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 32'h1000_0020, 1'b0, 32'h0000_0024, 32'd8};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 32'h1000_0020, 1'b0, 32'h0000_0024, 32'd8};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0020, 32'h1000_0020, 1'b0, 32'hFFFF_FFFC, 32'd8};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'd9};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 32'h3C03_C000, 1'b0, 32'h0000_0004, 32'd10};

        resetn          = 1'b0;
        fetch_en        = 1'b1;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset id_valid", {31'd0, id_valid}, 32'd0);
        chk("reset id_fault", {31'd0, id_fault}, 32'd0);
        chk("reset id_inst", id_inst, 32'h0);
        chk("reset id_pc", id_pc, 32'h0);
        chk("reset id_pc4", id_pc4, 32'h0);
        chk("reset fetch_count", fetch_count, 32'd0);
        chk("reset imem_a", imem_a, 32'h0);
        #2 resetn = 1'b1;
        #1;
        chk("first cycle imem_a", imem_a, 32'h0);

        for (int i = 0; i < 21; i++) apply(i);

        // Asynchronous reset in the middle of a stalled, valid slot.
        fetch_en = 1'b1;
        id_ready = 1'b0;
        @(posedge clock);
        #3;
        chk("pre-reset id_valid", {31'd0, id_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("async reset id_valid", {31'd0, id_valid}, 32'd0);
        chk("async reset imem_a", imem_a, 32'h0);
        chk("async reset fetch_count", fetch_count, 32'd0);
        chk("async reset id_inst", id_inst, 32'h0);
        @(posedge clock);
        #2;
        id_ready = 1'b1;
        resetn   = 1'b1;
        #1;
        chk("restart imem_a", imem_a, 32'h0);
        for (int i = 0; i < 3; i++) apply(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
